// File: rtl/shift_exec_pipe.sv
// Two-stage RV32I shift execute unit: decode + operand prep in S1, log right shifter feeding S2.
// Optional saturating handshake counters are built when SHIFT_STATS_EN is defined.
module shift_exec_pipe #(
    parameter int XLEN = 32,
    parameter int TAGW = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_funct3,
    input  logic            in_funct7b5,
    input  logic            in_use_imm,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [4:0]      in_imm,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [TAGW-1:0] out_tag,
    output logic            out_illegal,
    output logic [15:0]     stat_ops,
    output logic [15:0]     stat_illegal
);

    localparam int SHW = 5;

    typedef enum logic [1:0] {
        OP_SLL = 2'd0,
        OP_SRL = 2'd1,
        OP_SRA = 2'd2,
        OP_ILL = 2'd3
    } op_e;

    function automatic logic [XLEN-1:0] rev(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        for (int i = 0; i < XLEN; i++) begin
            r[i] = v[XLEN-1-i];
        end
        return r;
    endfunction

    // Only the low five bits of rs2 carry the shift amount.
    logic unused_rs2;
    assign unused_rs2 = ^in_rs2[XLEN-1:SHW];

    op_e             dec_op;
    logic            dec_ill;
    logic [SHW-1:0]  dec_shamt;
    logic [XLEN-1:0] dec_opnd;

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        dec_op  = OP_ILL;
        dec_ill = 1'b1;
        if (in_funct3 == 3'b001 && !in_funct7b5) begin
            dec_op  = OP_SLL;
            dec_ill = 1'b0;
        end else if (in_funct3 == 3'b101) begin
            dec_op  = in_funct7b5 ? OP_SRA : OP_SRL;
            dec_ill = 1'b0;
        end
        dec_shamt = in_use_imm ? in_imm : in_rs2[SHW-1:0];
        // SLL rides the right shifter on a bit-reversed operand.
        dec_opnd  = (dec_op == OP_SLL) ? rev(in_rs1) : in_rs1;
    end

    logic            s1_valid;
    op_e             s1_op;
    logic [SHW-1:0]  s1_shamt;
    logic [XLEN-1:0] s1_opnd;
    logic [TAGW-1:0] s1_tag;
    logic            s1_ill;

    logic            s2_valid;
    logic            s2_adv;

    assign s2_adv   = s1_valid && (!s2_valid || out_ready);
    assign in_ready = !flush && (!s1_valid || s2_adv);

    // NOTE: pipeline data registers are reset too, so out_* read as zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= OP_ILL;
            s1_shamt <= '0;
            s1_opnd  <= '0;
            s1_tag   <= '0;
            s1_ill   <= 1'b0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (in_ready) begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_op    <= dec_op;
                s1_shamt <= dec_shamt;
                s1_opnd  <= dec_opnd;
                s1_tag   <= in_tag;
                s1_ill   <= dec_ill;
            end
        end
    end

    // Logarithmic right shifter: level g shifts by 2**g when shamt[g] is set.
    logic [SHW:0][XLEN-1:0] lvl;
    logic                   fill;
    logic [XLEN-1:0]        s1_result;

    assign fill   = (s1_op == OP_SRA) && s1_opnd[XLEN-1];
    assign lvl[0] = s1_opnd;

    for (genvar g = 0; g < SHW; g++) begin : g_shift
        localparam int D = 1 << g;
        assign lvl[g+1] = s1_shamt[g] ? {{D{fill}}, lvl[g][XLEN-1:D]} : lvl[g];
    end

    assign s1_result = s1_ill             ? '0
                     : (s1_op == OP_SLL)  ? rev(lvl[SHW])
                     :                      lvl[SHW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid    <= 1'b0;
            out_result  <= '0;
            out_tag     <= '0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            s2_valid <= 1'b0;
        end else if (s2_adv) begin
            s2_valid    <= 1'b1;
            out_result  <= s1_result;
            out_tag     <= s1_tag;
            out_illegal <= s1_ill;
        end else if (out_ready) begin
            s2_valid <= 1'b0;
        end
    end

    assign out_valid = s2_valid;

`ifdef SHIFT_STATS_EN
    logic        out_fire;
    logic [15:0] ops_q;
    logic [15:0] ill_q;

    // flush outranks the output handshake, so a flushed result is never counted.
    assign out_fire = s2_valid && out_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ops_q <= '0;
            ill_q <= '0;
        end else if (out_fire) begin
            if (ops_q != 16'hFFFF) ops_q <= ops_q + 16'd1;
            if (out_illegal && ill_q != 16'hFFFF) ill_q <= ill_q + 16'd1;
        end
    end

    assign stat_ops     = ops_q;
    assign stat_illegal = ill_q;
`else
    assign stat_ops     = '0;
    assign stat_illegal = '0;
`endif

endmodule

// File: tb/tb_shift_exec_pipe.sv
// Self-checking bench for shift_exec_pipe: directed vectors plus an arithmetic scoreboard
// checked every cycle at the falling edge.
module tb_shift_exec_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_funct3;
    logic        in_funct7b5;
    logic        in_use_imm;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic [4:0]  in_imm;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_tag;
    logic        out_illegal;
    logic [15:0] stat_ops;
    logic [15:0] stat_illegal;

    shift_exec_pipe #(.XLEN(32), .TAGW(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_funct3    (in_funct3),
        .in_funct7b5  (in_funct7b5),
        .in_use_imm   (in_use_imm),
        .in_rs1       (in_rs1),
        .in_rs2       (in_rs2),
        .in_imm       (in_imm),
        .in_tag       (in_tag),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_tag      (out_tag),
        .out_illegal  (out_illegal),
        .stat_ops     (stat_ops),
        .stat_illegal (stat_illegal)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  tag;
        logic        ill;
    } exp_t;

    // Reference behaviour straight from the RV32I shift definitions.
    function automatic exp_t model(input logic [2:0] f3, input logic b5, input logic ui,
                                   input logic [31:0] rs1, input logic [31:0] rs2,
                                   input logic [4:0] imm, input logic [4:0] tag);
        exp_t e;
        logic [4:0] sh;
        sh    = ui ? imm : rs2[4:0];
        e.tag = tag;
        e.ill = 1'b0;
        if (f3 == 3'b001 && !b5)     e.res = rs1 << sh;
        else if (f3 == 3'b101 && !b5) e.res = rs1 >> sh;
        else if (f3 == 3'b101 && b5)  e.res = $signed(rs1) >>> sh;
        else begin
            e.res = 32'h0;
            e.ill = 1'b1;
        end
        return e;
    endfunction

    exp_t        q[$];
    logic [15:0] m_ops = '0;
    logic [15:0] m_ill = '0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_res;
    logic [4:0]  prev_tag;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            q.delete();
            m_ops      = '0;
            m_ill      = '0;
            prev_stall = 1'b0;
        end else begin
            check("stat_ops", {16'h0, stat_ops}, {16'h0, m_ops});
            check("stat_illegal", {16'h0, stat_illegal}, {16'h0, m_ill});
            if (prev_stall) begin
                check("hold_valid", {31'h0, out_valid}, 32'h1);
                check("hold_result", out_result, prev_res);
                check("hold_tag", {27'h0, out_tag}, {27'h0, prev_tag});
            end
            if (out_valid && out_ready && !flush) begin
                if (q.size() == 0) begin
                    check("spurious_output_queue_size", 32'h0, 32'h1);
                end else begin
                    e = q.pop_front();
                    check("sb_result", out_result, e.res);
                    check("sb_tag", {27'h0, out_tag}, {27'h0, e.tag});
                    check("sb_illegal", {31'h0, out_illegal}, {31'h0, e.ill});
`ifdef SHIFT_STATS_EN
                    if (m_ops != 16'hFFFF) m_ops = m_ops + 16'd1;
                    if (e.ill && m_ill != 16'hFFFF) m_ill = m_ill + 16'd1;
`endif
                end
            end
            if (flush) q.delete();
            if (in_valid && in_ready)
                q.push_back(model(in_funct3, in_funct7b5, in_use_imm, in_rs1, in_rs2, in_imm, in_tag));
            prev_stall = out_valid && !out_ready && !flush;
            prev_res   = out_result;
            prev_tag   = out_tag;
        end
    end

    task automatic set_in(input logic [2:0] f3, input logic b5, input logic ui,
                          input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [4:0] imm, input logic [4:0] tag);
        in_valid    = 1'b1;
        in_funct3   = f3;
        in_funct7b5 = b5;
        in_use_imm  = ui;
        in_rs1      = rs1;
        in_rs2      = rs2;
        in_imm      = imm;
        in_tag      = tag;
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the op.
    task automatic send(input logic [2:0] f3, input logic b5, input logic ui,
                        input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [4:0] imm, input logic [4:0] tag);
        bit done;
        done = 1'b0;
        set_in(f3, b5, ui, rs1, rs2, imm, tag);
        for (int t = 0; t < 50 && !done; t++) begin
            #1;
            done = in_ready;
            @(posedge clk);
            #1;
        end
        if (!done) check("send_timeout", 32'h0, 32'h1);
    endtask

    // Called right after the accept edge with in_valid dropped and out_ready high.
    task automatic expect_out(input string name, input logic [31:0] res,
                              input logic [4:0] tag, input logic ill);
        check({name, "_not_early"}, {31'h0, out_valid}, 32'h0);
        @(posedge clk);
        #1;
        check({name, "_valid"}, {31'h0, out_valid}, 32'h1);
        check({name, "_result"}, out_result, res);
        check({name, "_tag"}, {27'h0, out_tag}, {27'h0, tag});
        check({name, "_illegal"}, {31'h0, out_illegal}, {31'h0, ill});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] so, si;
        logic [31:0] held;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_funct3 = '0; in_funct7b5 = 1'b0; in_use_imm = 1'b0;
        in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_tag = '0;
        #1;
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_out_result", out_result, 32'h0);
        check("rst_out_tag", {27'h0, out_tag}, 32'h0);
        check("rst_out_illegal", {31'h0, out_illegal}, 32'h0);
        check("rst_stat_ops", {16'h0, stat_ops}, 32'h0);
        check("rst_stat_illegal", {16'h0, stat_illegal}, 32'h0);
        @(posedge clk); @(posedge clk);
        #2 rst_n = 1'b1;
        #1 check("rst_in_ready", {31'h0, in_ready}, 32'h1);
        @(posedge clk);
        #1;

        // Single operations with hand-computed results.
        send(3'b101, 1'b1, 1'b0, 32'h8000_00F0, 32'hFFFF_FFE4, 5'd0, 5'd3);
        in_valid = 1'b0;
        expect_out("sra4", 32'hF800_000F, 5'd3, 1'b0);

        send(3'b001, 1'b0, 1'b1, 32'h0000_0003, 32'h1234_5678, 5'd31, 5'd4);
        in_valid = 1'b0;
        expect_out("sll_imm31", 32'h8000_0000, 5'd4, 1'b0);

        send(3'b101, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'hFFFF_FFE0, 5'd7, 5'd5);
        in_valid = 1'b0;
        expect_out("srl_sh0", 32'hDEAD_BEEF, 5'd5, 1'b0);

        send(3'b001, 1'b0, 1'b0, 32'h0000_00FF, 32'h0000_0008, 5'd0, 5'd6);
        in_valid = 1'b0;
        expect_out("sll_reg8", 32'h0000_FF00, 5'd6, 1'b0);

        send(3'b101, 1'b0, 1'b1, 32'h8000_0000, 32'h0, 5'd31, 5'd7);
        in_valid = 1'b0;
        expect_out("srl_imm31", 32'h0000_0001, 5'd7, 1'b0);

        si = stat_illegal;
        send(3'b001, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h1, 5'd0, 5'd8);
        in_valid = 1'b0;
        expect_out("illegal_sll_b5", 32'h0, 5'd8, 1'b1);
`ifdef SHIFT_STATS_EN
        check("illegal_stat_delta", {16'h0, stat_illegal}, {16'h0, si + 16'd1});
`else
        check("illegal_stat_tied", {16'h0, stat_illegal}, 32'h0);
`endif

        send(3'b010, 1'b0, 1'b0, 32'h1234_5678, 32'h2, 5'd0, 5'd9);
        in_valid = 1'b0;
        expect_out("illegal_f3_010", 32'h0, 5'd9, 1'b1);

        // Back-to-back streaming with out_ready held high.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_in((i % 3 == 0) ? 3'b001 : 3'b101, (i % 3 == 2), i[0],
                   32'h9E37_79B9 ^ (i * 32'h0101_0101), i * 5 + 1, 5'(i * 3), 5'(10 + i));
            #1 check("stream_in_ready", {31'h0, in_ready}, 32'h1);
            @(posedge clk);
            #1;
            if (i >= 1) begin
                check("stream_valid", {31'h0, out_valid}, 32'h1);
                check("stream_tag", {27'h0, out_tag}, 32'(10 + i - 1));
            end
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("stream_last_tag", {27'h0, out_tag}, 32'd17);
        check("stream_last_valid", {31'h0, out_valid}, 32'h1);
        @(posedge clk);
        #1;
        check("stream_drained", {31'h0, out_valid}, 32'h0);

        // Backpressure: two accepts fill the pipe, then in_ready drops.
        out_ready = 1'b0;
        set_in(3'b101, 1'b1, 1'b0, 32'hF000_1234, 32'd8, 5'd0, 5'd20);
        #1 check("bp_ready_a", {31'h0, in_ready}, 32'h1);
        @(posedge clk);
        #1;
        set_in(3'b001, 1'b0, 1'b1, 32'h0000_ABCD, 32'd0, 5'd12, 5'd21);
        #1 check("bp_ready_b", {31'h0, in_ready}, 32'h1);
        @(posedge clk);
        #1;
        set_in(3'b101, 1'b0, 1'b0, 32'hCAFE_F00D, 32'd16, 5'd0, 5'd22);
        #1 check("bp_ready_c_blocked", {31'h0, in_ready}, 32'h0);
        check("bp_head_tag", {27'h0, out_tag}, 32'd20);
        held = out_result;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #2;
            check("bp_stall_ready", {31'h0, in_ready}, 32'h0);
            check("bp_stall_tag", {27'h0, out_tag}, 32'd20);
            check("bp_stall_result", out_result, held);
        end
        out_ready = 1'b1;
        #1 check("bp_release_ready", {31'h0, in_ready}, 32'h1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_next_valid", {31'h0, out_valid}, 32'h1);
        check("bp_next_tag", {27'h0, out_tag}, 32'd21);
        @(posedge clk);
        #1;
        check("bp_third_valid", {31'h0, out_valid}, 32'h1);
        check("bp_third_tag", {27'h0, out_tag}, 32'd22);
        @(posedge clk);
        #1;
        check("bp_drained", {31'h0, out_valid}, 32'h0);

        // Flush with both stages full, racing an output handshake and a new offer.
        out_ready = 1'b0;
        send(3'b101, 1'b0, 1'b0, 32'h1111_0000, 32'd4, 5'd0, 5'd30);
        send(3'b001, 1'b0, 1'b0, 32'h0000_1111, 32'd4, 5'd0, 5'd31);
        so = stat_ops;
        si = stat_illegal;
        set_in(3'b101, 1'b1, 1'b0, 32'h8000_0000, 32'd1, 5'd0, 5'd1);
        flush     = 1'b1;
        out_ready = 1'b1;
        #1 check("flush_in_ready", {31'h0, in_ready}, 32'h0);
        check("flush_pre_valid", {31'h0, out_valid}, 32'h1);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", {31'h0, out_valid}, 32'h0);
        check("flush_stat_ops", {16'h0, stat_ops}, {16'h0, so});
        check("flush_stat_illegal", {16'h0, stat_illegal}, {16'h0, si});
        @(posedge clk);
        #1;
        check("flush_s1_gone", {31'h0, out_valid}, 32'h0);

        // Asynchronous reset with the pipe full.
        out_ready = 1'b0;
        send(3'b101, 1'b1, 1'b0, 32'h8765_4321, 32'd3, 5'd0, 5'd12);
        send(3'b101, 1'b1, 1'b0, 32'h0765_4321, 32'd3, 5'd0, 5'd13);
        set_in(3'b001, 1'b0, 1'b0, 32'h1, 32'd1, 5'd0, 5'd14);
        #1;
        check("arst_pre_valid", {31'h0, out_valid}, 32'h1);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("arst_out_valid", {31'h0, out_valid}, 32'h0);
        check("arst_out_result", out_result, 32'h0);
        check("arst_out_tag", {27'h0, out_tag}, 32'h0);
        check("arst_out_illegal", {31'h0, out_illegal}, 32'h0);
        check("arst_stat_ops", {16'h0, stat_ops}, 32'h0);
        check("arst_stat_illegal", {16'h0, stat_illegal}, 32'h0);
        @(posedge clk);
        #2;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("arst_no_output", {31'h0, out_valid}, 32'h0);
        @(posedge clk);
        #1;
        check("arst_still_empty", {31'h0, out_valid}, 32'h0);
        check("arst_in_ready", {31'h0, in_ready}, 32'h1);

        // One more op after reset to confirm the pipe restarts cleanly.
        send(3'b101, 1'b1, 1'b0, 32'h8000_0000, 32'd31, 5'd0, 5'd2);
        in_valid = 1'b0;
        expect_out("post_rst_sra31", 32'hFFFF_FFFF, 5'd2, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", q.size(), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
